// File: rtl/bram_image_writer_if.sv
// Byte-stream valid/ready channel feeding the image BRAM writer.
// The source drives data/valid; the writer drives ready.
interface bram_image_writer_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready
    );
endinterface

// File: rtl/bram_image_writer.sv
// Frame loader: unpacks a byte stream (3 bytes -> 2 x 12-bit pixels) into sequential
// writes on the image BRAM write port, terminating after IMG_W*IMG_H pixels.
module bram_image_writer #(
    parameter int unsigned IMG_W  = 320,
    parameter int unsigned IMG_H  = 320,
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned PIX_W  = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic                  abort_i,
    bram_image_writer_if.slave    s_if,
    output logic                  bram_we_o,
    output logic [ADDR_W-1:0]     bram_addr_o,
    output logic [PIX_W-1:0]      bram_din_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_W-1:0]     pixel_count_o
);

    localparam int unsigned          NPix    = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0]    LastPtr = ADDR_W'(NPix - 1);

    if (PIX_W != 12) begin : g_bad_pix_w
        $error("bram_image_writer: packing requires PIX_W == 12");
    end
    if ((NPix % 2) != 0) begin : g_odd_frame
        $error("bram_image_writer: IMG_W*IMG_H must be even");
    end
    if (longint'(NPix) > (longint'(1) << ADDR_W)) begin : g_addr_small
        $error("bram_image_writer: frame does not fit in ADDR_W address bits");
    end

    typedef enum logic [1:0] {
        StIdle,
        StB0,
        StB1,
        StB2
    } state_e;

    state_e              state_q;
    logic [7:0]          b0_q;
    logic [3:0]          b1_hi_q;
    logic [ADDR_W-1:0]   wr_ptr_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [PIX_W-1:0]    din_q;
    logic                busy_q;
    logic                done_q;
    logic [ADDR_W-1:0]   pix_cnt_q;

    logic                s_ready;
    logic                accept;

    // Ready depends only on state and abort, never on s_valid.
    assign s_ready     = (state_q != StIdle) && !abort_i;
    assign accept      = s_if.s_valid && s_ready;
    assign s_if.s_ready = s_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            b0_q      <= '0;
            b1_hi_q   <= '0;
            wr_ptr_q  <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            din_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pix_cnt_q <= '0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            if (abort_i) begin
                // Any partially latched pixel is dropped; a write registered last
                // edge has already been presented and is unaffected.
                state_q <= StIdle;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start_i) begin
                            state_q   <= StB0;
                            busy_q    <= 1'b1;
                            pix_cnt_q <= '0;
                            wr_ptr_q  <= '0;
                        end
                    end
                    StB0: begin
                        if (accept) begin
                            b0_q    <= s_if.s_data;
                            state_q <= StB1;
                        end
                    end
                    StB1: begin
                        if (accept) begin
                            we_q      <= 1'b1;
                            addr_q    <= wr_ptr_q;
                            din_q     <= {s_if.s_data[3:0], b0_q};
                            wr_ptr_q  <= wr_ptr_q + ADDR_W'(1);
                            pix_cnt_q <= pix_cnt_q + ADDR_W'(1);
                            b1_hi_q   <= s_if.s_data[7:4];
                            state_q   <= StB2;
                        end
                    end
                    StB2: begin
                        if (accept) begin
                            we_q      <= 1'b1;
                            addr_q    <= wr_ptr_q;
                            din_q     <= {s_if.s_data, b1_hi_q};
                            wr_ptr_q  <= wr_ptr_q + ADDR_W'(1);
                            pix_cnt_q <= pix_cnt_q + ADDR_W'(1);
                            if (wr_ptr_q == LastPtr) begin
                                state_q <= StIdle;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= StB0;
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign bram_we_o     = we_q;
    assign bram_addr_o   = addr_q;
    assign bram_din_o    = din_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign pixel_count_o = pix_cnt_q;

endmodule

// File: tb/tb_bram_image_writer.sv
// Self-checking bench for bram_image_writer: packing table, randomized full frame with a
// byte-level reference model, abort, idle backpressure and asynchronous reset cases.
module tb_bram_image_writer;

    localparam int unsigned IW   = 32;
    localparam int unsigned IH   = 24;
    localparam int unsigned AW   = 17;
    localparam int unsigned NPix = IW * IH;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic [11:0]   bram_din;
    logic          busy;
    logic          done;
    logic [AW-1:0] pixel_count;

    bram_image_writer_if s_if ();

    bram_image_writer #(
        .IMG_W  (IW),
        .IMG_H  (IH),
        .ADDR_W (AW),
        .PIX_W  (12)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start_i       (start),
        .abort_i       (abort),
        .s_if          (s_if),
        .bram_we_o     (bram_we),
        .bram_addr_o   (bram_addr),
        .bram_din_o    (bram_din),
        .busy_o        (busy),
        .done_o        (done),
        .pixel_count_o (pixel_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_writes = 0;
    int n_done   = 0;
    bit sb_en    = 1'b0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [11:0]   data;
    } wr_t;

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [11:0] p0;
        logic [11:0] p1;
    } vec_t;

    wr_t        exp_q[$];
    logic [7:0] frame_bytes[$];
    vec_t       vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: every completed byte pair/triple yields one pixel at the index
    // given by its position in the frame's byte stream.
    function automatic void model_accept(input logic [7:0] b);
        int  n;
        wr_t w;
        frame_bytes.push_back(b);
        n = frame_bytes.size();
        if (n % 3 == 2) begin
            w.addr = AW'(2 * (n / 3));
            w.data = {frame_bytes[n-1][3:0], frame_bytes[n-2]};
            exp_q.push_back(w);
        end else if (n % 3 == 0) begin
            w.addr = AW'(2 * (n / 3) - 1);
            w.data = {frame_bytes[n-1], frame_bytes[n-2][7:4]};
            exp_q.push_back(w);
        end
    endfunction

    function automatic int pixels_for(input int nbytes);
        return 2 * (nbytes / 3) + ((nbytes % 3 == 2) ? 1 : 0);
    endfunction

    always @(negedge clk) begin
        wr_t w;
        if (sb_en && !reset) begin
            if (bram_we) begin
                n_writes++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_write: addr 0x%0h data 0x%0h, required no write",
                             bram_addr, bram_din);
                end else begin
                    w = exp_q.pop_front();
                    check("wr_addr", 32'(bram_addr), 32'(w.addr));
                    check("wr_data", 32'(bram_din), 32'(w.data));
                end
            end
            if (done) begin
                n_done++;
                check("done_on_last_write", 32'({bram_we, bram_addr}),
                      32'({1'b1, AW'(NPix - 1)}));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        s_if.s_valid = 1'b0;
        s_if.s_data  = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        exp_q.delete();
        frame_bytes.delete();
        tick();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        frame_bytes.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        s_if.s_data  = b;
        s_if.s_valid = 1'b1;
        @(negedge clk);
        while (!s_if.s_ready && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (!s_if.s_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL s_ready_timeout: s_ready 0 for 1000 cycles, required 1");
        end else begin
            @(posedge clk);
            if (sb_en) model_accept(b);
        end
        #1;
        s_if.s_valid = 1'b0;
    endtask

    task automatic idle_gap(input int n);
        repeat (n) begin
            s_if.s_valid = 1'b0;
            s_if.s_data  = 8'($urandom);
            tick();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb_list[2];
        vecs[0] = '{b0: 8'hBC, b1: 8'h3A, b2: 8'h12, p0: 12'hABC, p1: 12'h123};
        vecs[1] = '{b0: 8'h00, b1: 8'h00, b2: 8'h00, p0: 12'h000, p1: 12'h000};
        vecs[2] = '{b0: 8'hFF, b1: 8'hFF, b2: 8'hFF, p0: 12'hFFF, p1: 12'hFFF};
        vecs[3] = '{b0: 8'h01, b1: 8'hF0, b2: 8'hA5, p0: 12'h001, p1: 12'hA5F};
        vecs[4] = '{b0: 8'h34, b1: 8'h12, b2: 8'h56, p0: 12'h234, p1: 12'h561};
        nb_list[0] = 7;
        nb_list[1] = 8;

        do_reset();
        check("rst_we", 32'(bram_we), 0);
        check("rst_addr", 32'(bram_addr), 0);
        check("rst_din", 32'(bram_din), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_pixel_count", 32'(pixel_count), 0);
        check("rst_s_ready", 32'(s_if.s_ready), 0);

        // Packing table: one pixel pair per vector, continuous valid.
        for (int i = 0; i < 5; i++) begin
            do_reset();
            do_start();
            check("vec_busy_after_start", 32'(busy), 1);
            s_if.s_valid = 1'b1;
            s_if.s_data  = vecs[i].b0;
            tick();
            check("vec_no_write_b0", 32'(bram_we), 0);
            s_if.s_data = vecs[i].b1;
            tick();
            check("vec_we_p0", 32'(bram_we), 1);
            check("vec_addr_p0", 32'(bram_addr), 0);
            check("vec_din_p0", 32'(bram_din), 32'(vecs[i].p0));
            s_if.s_data = vecs[i].b2;
            tick();
            check("vec_we_p1", 32'(bram_we), 1);
            check("vec_addr_p1", 32'(bram_addr), 1);
            check("vec_din_p1", 32'(bram_din), 32'(vecs[i].p1));
            check("vec_pixel_count", 32'(pixel_count), 2);
            check("vec_busy", 32'(busy), 1);
            check("vec_no_done", 32'(done), 0);
            s_if.s_valid = 1'b0;
            tick();
            check("vec_we_drop", 32'(bram_we), 0);
            check("vec_din_hold", 32'(bram_din), 32'(vecs[i].p1));
        end

        // Valid without start in IDLE: no ready, no writes.
        do_reset();
        sb_en        = 1'b1;
        s_if.s_valid = 1'b1;
        s_if.s_data  = 8'h5A;
        repeat (3) begin
            tick();
            check("idle_s_ready", 32'(s_if.s_ready), 0);
            check("idle_we", 32'(bram_we), 0);
        end
        s_if.s_valid = 1'b0;

        // Full frame with random gaps and a start pulse while busy.
        do_start();
        for (int i = 0; i < int'(NPix * 3 / 2); i++) begin
            idle_gap(int'($urandom_range(0, 2)));
            if (i == int'(NPix / 2)) begin
                check("busy_mid_frame", 32'(busy), 1);
                start = 1'b1;
                tick();
                start = 1'b0;
            end
            send_byte(8'($urandom));
        end
        check("frame_done_with_final", 32'(done), 1);
        tick();
        check("frame_done_one_cycle", 32'(done), 0);
        check("frame_busy_low", 32'(busy), 0);
        check("frame_pixel_count", 32'(pixel_count), 32'(NPix));
        check("frame_s_ready_low", 32'(s_if.s_ready), 0);
        check("frame_write_count", 32'(n_writes), 32'(NPix));
        check("frame_done_count", 32'(n_done), 1);
        check("frame_queue_empty", 32'(exp_q.size()), 0);
        tick();
        check("frame_pixel_count_hold", 32'(pixel_count), 32'(NPix));

        // Abort mid-pixel with a byte presented, then a fresh frame from address 0.
        for (int k = 0; k < 2; k++) begin
            do_start();
            for (int j = 0; j < nb_list[k]; j++) send_byte(8'($urandom));
            abort        = 1'b1;
            s_if.s_valid = 1'b1;
            s_if.s_data  = 8'hEE;
            #1;
            check("abort_s_ready_low", 32'(s_if.s_ready), 0);
            tick();
            abort        = 1'b0;
            s_if.s_valid = 1'b0;
            check("abort_busy_low", 32'(busy), 0);
            check("abort_pixel_count", 32'(pixel_count), 32'(pixels_for(nb_list[k])));
            tick();
            check("abort_no_done", 32'(n_done), 1);
            check("abort_queue_empty", 32'(exp_q.size()), 0);
            check("abort_pixel_count_hold", 32'(pixel_count), 32'(pixels_for(nb_list[k])));
            do_start();
            for (int j = 0; j < 3; j++) send_byte(8'($urandom));
            tick();
            check("restart_queue_empty", 32'(exp_q.size()), 0);
            check("restart_pixel_count", 32'(pixel_count), 2);
            abort = 1'b1;
            tick();
            abort = 1'b0;
        end

        // Abort and start together in IDLE: abort wins.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("abort_start_busy", 32'(busy), 0);
        check("abort_start_s_ready", 32'(s_if.s_ready), 0);
        do_start();
        check("start_after_abort_busy", 32'(busy), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // Asynchronous reset between edges while a write is on the port.
        do_start();
        send_byte(8'h11);
        send_byte(8'h22);
        check("pre_reset_we", 32'(bram_we), 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_we", 32'(bram_we), 0);
        check("async_rst_addr", 32'(bram_addr), 0);
        check("async_rst_din", 32'(bram_din), 0);
        check("async_rst_busy", 32'(busy), 0);
        check("async_rst_done", 32'(done), 0);
        check("async_rst_pixel_count", 32'(pixel_count), 0);
        check("async_rst_s_ready", 32'(s_if.s_ready), 0);
        exp_q.delete();
        frame_bytes.delete();
        tick();
        tick();
        reset = 1'b0;
        tick();
        do_start();
        send_byte(8'hBC);
        send_byte(8'h3A);
        send_byte(8'h12);
        tick();
        check("post_reset_queue_empty", 32'(exp_q.size()), 0);
        check("post_reset_pixel_count", 32'(pixel_count), 2);
        check("post_reset_last_din", 32'(bram_din), 32'h123);
        check("post_reset_last_addr", 32'(bram_addr), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
